// File: rtl/platform_pkg.sv
// rtl/platform_pkg.sv - shared platform Wishbone sizing and DDR3 arbiter types
package platform_pkg;

  localparam int SEC_WB_AW = 32;
  localparam int SEC_WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2,
    DRAIN  = 2'd3
  } ddr3_arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } ddr3_arb_master_t;

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - pipelined Wishbone bus bundle with master/slave views
interface wishbone_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            ack;
  logic            err;
  logic            stall;

  modport master (
    output cyc, stb, we, addr, sel, wdata,
    input  rdata, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, addr, sel, wdata,
    output rdata, ack, err, stall
  );

endinterface

// File: rtl/wb_outstanding_cnt.sv
// rtl/wb_outstanding_cnt.sv - accepted-but-unanswered request counter with saturation
module wb_outstanding_cnt #(
  parameter int MAX_OUTSTANDING = 8,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic accept_i,
  input  logic resp_i,
  input  logic clear_i,
  output logic full_o,
  output logic empty_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          inc;
  logic          dec;

  assign full_o  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty_o = (count_q == '0);

  // A response with nothing in flight is spurious and never moves the count;
  // an accept while full cannot happen because the arbiter gates stb, but is
  // ignored here as well so the count can never wrap.
  always_comb begin
    inc     = accept_i & ~full_o;
    dec     = resp_i & ~empty_o;
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc && !dec) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ddr3_wb_arbiter.sv
// rtl/ddr3_wb_arbiter.sv - two-master round-robin Wishbone arbiter for the DDR3 port (watchdog: DDR3_WB_ARB_TIMEOUT_EN)
module ddr3_wb_arbiter
  import platform_pkg::*;
#(
  parameter int AW              = SEC_WB_AW,
  parameter int DW              = SEC_WB_DW,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  wishbone_if.slave  m0_wb_if,
  wishbone_if.slave  m1_wb_if,
  wishbone_if.master s_wb_if
`ifdef DDR3_WB_ARB_TIMEOUT_EN
  ,
  output logic       timeout_o
`endif
);

  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ddr3_wb_arbiter: MAX_OUTSTANDING must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
  end

  ddr3_arb_state_t  state_q;
  ddr3_arb_state_t  state_d;
  ddr3_arb_master_t last_grant_q;
  ddr3_arb_master_t last_grant_d;

  logic            cnt_full;
  logic            cnt_empty;
  logic            s_accept;
  logic            s_resp;
  logic            wd_fire;

  logic            g_cyc;
  logic            g_stb;
  logic            g_we;
  logic [AW-1:0]   g_addr;
  logic [DW/8-1:0] g_sel;
  logic [DW-1:0]   g_wdata;

  assign s_accept = s_wb_if.stb & ~s_wb_if.stall;
  assign s_resp   = s_wb_if.ack | s_wb_if.err;

  wb_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_outstanding (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .accept_i (s_accept),
    .resp_i   (s_resp),
    .clear_i  (wd_fire),
    .full_o   (cnt_full),
    .empty_o  (cnt_empty)
  );

  // Request side of whichever master the grant state points at.
  always_comb begin
    if (state_q == GNT_M1) begin
      g_cyc   = m1_wb_if.cyc;
      g_stb   = m1_wb_if.stb;
      g_we    = m1_wb_if.we;
      g_addr  = m1_wb_if.addr;
      g_sel   = m1_wb_if.sel;
      g_wdata = m1_wb_if.wdata;
    end else begin
      g_cyc   = m0_wb_if.cyc;
      g_stb   = m0_wb_if.stb;
      g_we    = m0_wb_if.we;
      g_addr  = m0_wb_if.addr;
      g_sel   = m0_wb_if.sel;
      g_wdata = m0_wb_if.wdata;
    end
  end

  // Next-state logic and bus routing; reset forces the idle bus picture.
  always_comb begin
    s_wb_if.cyc    = 1'b0;
    s_wb_if.stb    = 1'b0;
    s_wb_if.we     = 1'b0;
    s_wb_if.addr   = '0;
    s_wb_if.sel    = '0;
    s_wb_if.wdata  = '0;
    m0_wb_if.rdata = '0;
    m0_wb_if.ack   = 1'b0;
    m0_wb_if.err   = 1'b0;
    m0_wb_if.stall = 1'b1;
    m1_wb_if.rdata = '0;
    m1_wb_if.ack   = 1'b0;
    m1_wb_if.err   = 1'b0;
    m1_wb_if.stall = 1'b1;
    state_d        = state_q;
    last_grant_d   = last_grant_q;

    if (rstn_i) begin
      unique case (state_q)
        IDLE: begin
          if (m0_wb_if.cyc && m1_wb_if.cyc) begin
            state_d = (last_grant_q == M0) ? GNT_M1 : GNT_M0;
          end else if (m0_wb_if.cyc) begin
            state_d = GNT_M0;
          end else if (m1_wb_if.cyc) begin
            state_d = GNT_M1;
          end
        end

        GNT_M0, GNT_M1: begin
          // Keep cyc up in the cycle the master lets go if responses are
          // still owed, so the controller never sees the cycle abandoned.
          s_wb_if.cyc   = g_cyc | ~cnt_empty;
          s_wb_if.stb   = g_cyc & g_stb & ~cnt_full;
          s_wb_if.we    = g_we;
          s_wb_if.addr  = g_addr;
          s_wb_if.sel   = g_sel;
          s_wb_if.wdata = g_wdata;
          if (state_q == GNT_M0) begin
            m0_wb_if.rdata = s_wb_if.rdata;
            m0_wb_if.ack   = s_wb_if.ack & ~cnt_empty;
            m0_wb_if.err   = s_wb_if.err & ~cnt_empty;
            m0_wb_if.stall = s_wb_if.stall | cnt_full;
          end else begin
            m1_wb_if.rdata = s_wb_if.rdata;
            m1_wb_if.ack   = s_wb_if.ack & ~cnt_empty;
            m1_wb_if.err   = s_wb_if.err & ~cnt_empty;
            m1_wb_if.stall = s_wb_if.stall | cnt_full;
          end
          if (!g_cyc) begin
            last_grant_d = (state_q == GNT_M0) ? M0 : M1;
            state_d      = cnt_empty ? IDLE : DRAIN;
          end
        end

        DRAIN: begin
          s_wb_if.cyc = 1'b1;
          if (cnt_empty) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase

      if (wd_fire) begin
        s_wb_if.cyc = 1'b0;
        s_wb_if.stb = 1'b0;
        state_d     = IDLE;
        if (state_q == GNT_M0) begin
          m0_wb_if.ack = 1'b0;
          m0_wb_if.err = 1'b1;
          last_grant_d = M0;
        end else if (state_q == GNT_M1) begin
          m1_wb_if.ack = 1'b0;
          m1_wb_if.err = 1'b1;
          last_grant_d = M1;
        end
      end
    end
  end

  // Arbiter state and round-robin history.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef DDR3_WB_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_cnt_q;
  logic [WDW-1:0] wd_cnt_d;
  logic           timeout_q;
  logic           timeout_d;

  // Watchdog: counts silent cycles while anything is in flight.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    wd_fire   = 1'b0;
    if (cnt_empty || s_resp) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1)) begin
      wd_fire   = 1'b1;
      wd_cnt_d  = '0;
      timeout_d = 1'b1;
    end else begin
      wd_cnt_d = wd_cnt_q + WDW'(1);
    end
  end

  // Watchdog count and sticky flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// tb/tb_ddr3_wb_arbiter.sv - self-checking bench for ddr3_wb_arbiter
module tb_ddr3_wb_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 8;
  localparam int TMO  = 16;
  localparam int NV   = 26;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wishbone_if #(.AW(AW), .DW(DW)) m0_if ();
  wishbone_if #(.AW(AW), .DW(DW)) m1_if ();
  wishbone_if #(.AW(AW), .DW(DW)) s_if ();

`ifdef DDR3_WB_ARB_TIMEOUT_EN
  logic timeout;
`endif

  ddr3_wb_arbiter #(
    .AW              (AW),
    .DW              (DW),
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .m0_wb_if (m0_if),
    .m1_wb_if (m1_if),
    .s_wb_if  (s_if)
`ifdef DDR3_WB_ARB_TIMEOUT_EN
    ,
    .timeout_o (timeout)
`endif
  );

  typedef struct packed {
    logic       m0c, m0s, m1c, m1s, sst, sack;
    logic [5:0] exp;  // s_cyc s_stb m0_stall m1_stall m0_ack m1_ack
  } vec_t;

  vec_t vt [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
    m0_if.addr = '0; m0_if.sel = '0; m0_if.wdata = '0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
    m1_if.addr = '0; m1_if.sel = '0; m1_if.wdata = '0;
    s_if.rdata = '0; s_if.ack = 1'b0; s_if.err = 1'b0; s_if.stall = 1'b0;
  endtask

  function automatic logic [5:0] ctl6();
    return {s_if.cyc, s_if.stb, m0_if.stall, m1_if.stall, m0_if.ack, m1_if.ack};
  endfunction

  // reference model state
  int         owner;
  bit         draining;
  int         outst;
  int         last;
  int         since_ack;

  initial begin
    logic [7:0]    e_ctl;
    logic [1:0]    e_st, e_ack, e_err, mc, ms;
    logic [AW-1:0] maddr [2];
    logic          e_scyc, e_sstb, acc, rsp;
    int            prev, n;
    bit            stalled, got;
    logic [AW-1:0] a;

    vt[0]  = 12'b110000_001100;
    vt[1]  = 12'b110000_110100;
    vt[2]  = 12'b110000_110100;
    vt[3]  = 12'b110000_110100;
    vt[4]  = 12'b110000_110100;
    vt[5]  = 12'b100001_100110;
    vt[6]  = 12'b100001_100110;
    vt[7]  = 12'b100001_100110;
    vt[8]  = 12'b100001_100110;
    vt[9]  = 12'b000000_000100;
    vt[10] = 12'b111100_001100;
    vt[11] = 12'b111100_111000;
    vt[12] = 12'b111001_101001;
    vt[13] = 12'b110000_001000;
    vt[14] = 12'b110000_001100;
    vt[15] = 12'b110000_110100;
    vt[16] = 12'b000000_100100;
    vt[17] = 12'b000001_101100;
    vt[18] = 12'b000000_101100;
    vt[19] = 12'b000000_001100;
    vt[20] = 12'b000001_001100;
    vt[21] = 12'b110000_001100;
    vt[22] = 12'b110001_110100;
    vt[23] = 12'b100001_100110;
    vt[24] = 12'b000000_000100;
    vt[25] = 12'b000000_001100;

    // reset: bus quiet, masters stalled even with a stray ack
    bus_idle();
    s_if.ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ctl6(), m0_if.err, m1_if.err}, 8'b00110000);
    chk("reset_s_addr", s_if.addr, 0);
    edge_drive();
    s_if.ack = 1'b0;
    rstn = 1'b1;

    // table: grant timing, pipelined reads, round robin, drain, spurious ack
    for (int i = 0; i < NV; i++) begin
      m0_if.cyc = vt[i].m0c; m0_if.stb = vt[i].m0s;
      m1_if.cyc = vt[i].m1c; m1_if.stb = vt[i].m1s;
      s_if.stall = vt[i].sst; s_if.ack = vt[i].sack;
      @(negedge clk);
      chk($sformatf("vec%0d", i), ctl6(), vt[i].exp);
      edge_drive();
    end
    bus_idle();
    edge_drive();

    // M1 ten back-to-back writes against a slow slave
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'h100;
    @(negedge clk); chk("m1_first_cycle_stall", m1_if.stall, 1); edge_drive();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("wr_accept", m1_if.stall, 0);
      chk("wr_addr_routed", s_if.addr, m1_if.addr);
      chk("wr_we_routed", s_if.we, 1);
      edge_drive();
      m1_if.addr = m1_if.addr + 4;
    end
    @(negedge clk);
    chk("full_stall", m1_if.stall, 1);
    chk("full_stb_low", s_if.stb, 0);
    edge_drive();
    s_if.ack = 1'b1;
    @(negedge clk);
    chk("full_ack_routed", m1_if.ack, 1);
    chk("full_still_stalled", m1_if.stall, 1);
    edge_drive();
    s_if.ack = 1'b0;
    @(negedge clk); chk("resume_after_ack", m1_if.stall, 0); edge_drive();
    s_if.ack = 1'b1;
    @(negedge clk); chk("refull_stall", m1_if.stall, 1); edge_drive();
    s_if.ack = 1'b0;
    @(negedge clk); chk("tenth_accept", m1_if.stall, 0); edge_drive();
    m1_if.stb = 1'b0;
    s_if.ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("wr_ack", m1_if.ack, 1); edge_drive();
    end
    s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.we = 1'b0;
    edge_drive(); edge_drive();

    // ack and accept in the same cycle at five outstanding
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    @(negedge clk); chk("m0_first_cycle_stall", m0_if.stall, 1); edge_drive();
    repeat (5) begin
      @(negedge clk); chk("rd_accept", m0_if.stall, 0); edge_drive();
    end
    s_if.ack = 1'b1;
    @(negedge clk);
    chk("same_cycle_accept", m0_if.stall, 0);
    chk("same_cycle_ack", m0_if.ack, 1);
    edge_drive();
    s_if.ack = 1'b0;
    n = 0; stalled = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!stalled) begin
        @(negedge clk);
        if (m0_if.stall) stalled = 1'b1; else n++;
        edge_drive();
      end
    end
    chk("accepts_left_after_5", n, 3);
    m0_if.stb = 1'b0; s_if.ack = 1'b1;
    repeat (8) edge_drive();
    s_if.ack = 1'b0; m0_if.cyc = 1'b0;
    edge_drive(); edge_drive();

    // M0 leaves with three outstanding while M1 waits
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    edge_drive();
    repeat (3) edge_drive();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m1_if.cyc = 1'b1;
    @(negedge clk);
    chk("drain_enter_cyc_held", s_if.cyc, 1);
    chk("drain_enter_m1_stall", m1_if.stall, 1);
    edge_drive();
    s_if.ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("drain_swallow", {s_if.cyc, s_if.stb, m0_if.ack, m1_if.ack, m1_if.stall}, 5'b10001);
      edge_drive();
    end
    s_if.ack = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!got) begin
        @(negedge clk);
        if (!m1_if.stall) got = 1'b1;
        edge_drive();
      end
    end
    chk("m1_granted_after_drain", got, 1);
    m1_if.cyc = 1'b0;
    edge_drive(); edge_drive();

`ifdef DDR3_WB_ARB_TIMEOUT_EN
    // slave never answers: watchdog fires on the 16th silent cycle
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    edge_drive();
    @(negedge clk); chk("wd_accept", m0_if.stall, 0); edge_drive();
    m0_if.stb = 1'b0;
    n = 0;
    for (int k = 1; k <= 24; k++) begin
      if (n == 0) begin
        @(negedge clk);
        if (m0_if.err) begin
          n = k;
          chk("wd_s_cyc_low", s_if.cyc, 0);
        end
        edge_drive();
      end
    end
    chk("wd_err_cycle", n, TMO);
    @(negedge clk);
    chk("wd_timeout_flag", timeout, 1);
    chk("wd_back_to_idle", m0_if.stall, 1);
    edge_drive();
    m0_if.cyc = 1'b0;
    edge_drive();
`endif

    // randomized traffic against the reference model
    rstn = 1'b0; bus_idle();
    edge_drive(); edge_drive();
    rstn = 1'b1;
    owner = -1; draining = 1'b0; outst = 0; last = 1; since_ack = 0;
    mc = 2'b00; ms = 2'b00;
    for (int cyc_n = 0; cyc_n < 500; cyc_n++) begin
      for (int m = 0; m < 2; m++) begin
        if (mc[m]) mc[m] = ($urandom_range(0, 7) != 0);
        else       mc[m] = ($urandom_range(0, 3) == 0);
        ms[m] = mc[m] && ($urandom_range(0, 3) != 0);
        maddr[m] = $urandom;
      end
      m0_if.cyc = mc[0]; m0_if.stb = ms[0]; m0_if.addr = maddr[0];
      m1_if.cyc = mc[1]; m1_if.stb = ms[1]; m1_if.addr = maddr[1];
      m0_if.we = 1'($urandom_range(0, 1)); m1_if.we = 1'($urandom_range(0, 1));
      m0_if.wdata = $urandom; m1_if.wdata = $urandom;
      s_if.rdata = $urandom;
      s_if.stall = ($urandom_range(0, 3) == 0);
      s_if.ack = ($urandom_range(0, 2) == 0) || (since_ack >= 6);
      s_if.err = ($urandom_range(0, 19) == 0);
      since_ack = s_if.ack ? 0 : since_ack + 1;

      e_scyc = 1'b0; e_sstb = 1'b0; e_st = 2'b11; e_ack = 2'b00; e_err = 2'b00;
      if (owner >= 0) begin
        e_scyc = mc[owner] || (outst > 0);
        e_sstb = mc[owner] && ms[owner] && (outst < MAXO);
        e_st[owner]  = s_if.stall || (outst == MAXO);
        e_ack[owner] = s_if.ack && (outst > 0);
        e_err[owner] = s_if.err && (outst > 0);
      end else if (draining) begin
        e_scyc = 1'b1;
      end
      e_ctl = {e_scyc, e_sstb, e_st[0], e_st[1], e_ack[0], e_ack[1], e_err[0], e_err[1]};

      @(negedge clk);
      chk($sformatf("rand%0d_ctl", cyc_n),
          {ctl6(), m0_if.err, m1_if.err}, e_ctl);
      if (owner >= 0) begin
        a = maddr[owner];
        chk($sformatf("rand%0d_addr", cyc_n), s_if.addr, a);
        chk($sformatf("rand%0d_rdata", cyc_n),
            (owner == 0) ? m0_if.rdata : m1_if.rdata, s_if.rdata);
      end

      acc  = e_sstb && !s_if.stall;
      rsp  = (s_if.ack || s_if.err) && (outst > 0);
      prev = outst;
      outst = outst + (acc ? 1 : 0) - (rsp ? 1 : 0);
      if (owner >= 0) begin
        if (!mc[owner]) begin
          last = owner;
          draining = (prev != 0);
          owner = -1;
        end
      end else if (draining) begin
        if (prev == 0) draining = 1'b0;
      end else if (mc[0] && mc[1]) begin
        owner = 1 - last;
      end else if (mc[0]) begin
        owner = 0;
      end else if (mc[1]) begin
        owner = 1;
      end
      edge_drive();
    end

    // reset in the middle of a transfer abandons it silently
    bus_idle();
    rstn = 1'b0; edge_drive(); rstn = 1'b1;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    repeat (4) edge_drive();
    rstn = 1'b0; s_if.ack = 1'b1; s_if.err = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {ctl6(), m0_if.err, m1_if.err}, 8'b00110000);
    edge_drive();
    @(negedge clk);
    chk("midreset_held", {ctl6(), m0_if.err, m1_if.err}, 8'b00110000);
    edge_drive();
    bus_idle();
    rstn = 1'b1;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    @(negedge clk); chk("post_reset_idle", ctl6(), 6'b001100); edge_drive();
    n = 0; stalled = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!stalled) begin
        @(negedge clk);
        if (m0_if.stall) stalled = 1'b1; else n++;
        edge_drive();
      end
    end
    chk("post_reset_count_cleared", n, MAXO);
    bus_idle();
    edge_drive();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/ddr3_wb_arbiter.md
DDR3_WB_ARBITER -- requirements
Module: ddr3_wb_arbiter

Interface
REQ-001 SHALL have parameter AW, default SEC_WB_AW: wishbone address width.
REQ-002 SHALL have parameter DW, default SEC_WB_DW: wishbone data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8: maximum accepted-but-unacknowledged requests, power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit, used only with DDR3_WB_ARB_TIMEOUT_EN.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, which is also the DDR3 controller clock.
REQ-006 SHALL have port rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port m0_wb_if, wishbone_if slave modport, AW/DW: master 0, the HDMI framebuffer reader.
REQ-008 SHALL have port m1_wb_if, wishbone_if slave modport, AW/DW: master 1, the CPU/platform framebuffer writer.
REQ-009 SHALL have port s_wb_if, wishbone_if master modport, AW/DW: the shared DDR3 controller port.
REQ-010 SHALL have port timeout_o, output, 1 bit: sticky watchdog flag; present only with DDR3_WB_ARB_TIMEOUT_EN.

Function
REQ-011 SHALL implement a registered FSM with states IDLE, GNT_M0, GNT_M1 and DRAIN.
REQ-012 SHALL, in IDLE with a single cyc asserted, enter the GNT state of that master on the next edge.
REQ-013 SHALL, in IDLE with both cyc asserted, grant the master not granted last (round-robin); after reset, last_grant is M1, so M0 wins the first tie.
REQ-014 SHALL, while in GNT_Mx, combinationally route Mx's cyc, stb, we, addr, sel and wdata to s_wb_if, and route s_wb_if's rdata, ack, err and stall back to Mx (zero added latency).
REQ-015 SHALL drive the non-granted master with stall=1, ack=0 and err=0, and drive both masters so in IDLE and DRAIN.
REQ-016 SHALL keep an outstanding counter: +1 on an accepted request (s stb & !stall); -1 on s ack|err; unchanged when both occur in the same cycle.
REQ-017 SHALL, when outstanding equals MAX_OUTSTANDING, force stall=1 to the granted master and hold s stb=0.
REQ-018 SHALL, in GNT_Mx when Mx drops cyc with outstanding==0, go to IDLE and set last_grant=Mx.
REQ-019 SHALL, in GNT_Mx when Mx drops cyc with outstanding>0, go to DRAIN.
REQ-020 SHALL, in DRAIN, hold s cyc=1 and s stb=0, swallow ack/err, and go to IDLE once outstanding reaches 0.
REQ-021 SHALL drive s cyc, stb, we, addr, sel and wdata to 0 in IDLE.
REQ-022 SHALL treat an ack or err arriving while outstanding==0 as spurious: ignore it, and never let the counter go below 0.
REQ-023 SHALL make a grant visible one cycle after cyc rises; the requester sees stall=1 in that first cycle.

Reset
REQ-024 SHALL, while rstn_i is low at an edge, set state=IDLE, outstanding=0, last_grant=M1 and timeout_o=0.
REQ-025 SHALL hold all s_wb_if outputs at 0 and both masters' stall=1, ack=0, err=0 during reset.
REQ-026 SHALL, on reset mid-transfer, abandon outstanding responses without any error reporting to either master.

Configuration
REQ-027 SHALL, with DDR3_WB_ARB_TIMEOUT_EN defined, count cycles with outstanding>0 and no ack/err, clearing the count on any ack/err.
REQ-028 SHALL, with DDR3_WB_ARB_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES: pulse err=1 to the granted master for one cycle, clear outstanding, drive s cyc=0 for one cycle, set timeout_o, and go to IDLE.
REQ-029 SHALL, without DDR3_WB_ARB_TIMEOUT_EN, contain no watchdog logic and no timeout_o port, and wait indefinitely.

Structure
REQ-030 SHALL place the enum ddr3_arb_state_t (IDLE/GNT_M0/GNT_M1/DRAIN) and the enum ddr3_arb_master_t (M0/M1) in platform_pkg.
REQ-031 SHALL implement the outstanding counter, with its saturation and spurious-response rules, as sub-module wb_outstanding_cnt.

Verification
REQ-032 SHALL cover: M0 alone issues 4 pipelined reads -> granted on cycle 2, 4 acks routed to M0, return to IDLE, last_grant=M0.
REQ-033 SHALL cover: M0 and M1 raise cyc together after reset -> M0 granted; on the next tie after M0 finishes, M1 granted.
REQ-034 SHALL cover: M1 issues 10 back-to-back writes with the slave acking late, MAX_OUTSTANDING=8 -> M1 stalled after 8 accepts, resumes after the first ack.
REQ-035 SHALL cover: M0 drops cyc with 3 outstanding -> DRAIN, s cyc held, 3 acks swallowed, IDLE, then a pending M1 granted.
REQ-036 SHALL cover: ack and accept in the same cycle at outstanding=5 -> outstanding stays 5.
REQ-037 SHALL cover, with DDR3_WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: slave never acks -> err to the granted master on cycle 16, timeout_o=1, state IDLE.
